// File: rtl/video_pkg.sv
// Shared video types: coordinate width, empty-seed constant, box record and
// the active-area detector FSM states.
package video_pkg;
  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_MAX = 11'd2047;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t hstart;
    coord_t hend;
    coord_t vstart;
    coord_t vend;
  } box_t;

  typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} state_t;
endpackage

// File: rtl/bbox_accum.sv
// Per-pixel min/max bounding-box accumulator. A load seeds it from the current
// pixel (lit -> single-point box, unlit -> empty box).
module bbox_accum
  import video_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  input  logic   load,
  input  logic   pix_lit,
  input  coord_t hcont,
  input  coord_t vcont,
  output box_t   box,
  output logic   any_lit
);
  coord_t minx_q, maxx_q, miny_q, maxy_q;
  logic   any_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      minx_q <= COORD_MAX;
      miny_q <= COORD_MAX;
      maxx_q <= '0;
      maxy_q <= '0;
      any_q  <= 1'b0;
    end else if (load) begin
      minx_q <= pix_lit ? hcont : COORD_MAX;
      miny_q <= pix_lit ? vcont : COORD_MAX;
      maxx_q <= pix_lit ? hcont : '0;
      maxy_q <= pix_lit ? vcont : '0;
      any_q  <= pix_lit;
    end else if (en && pix_lit) begin
      if (hcont < minx_q) minx_q <= hcont;
      if (hcont > maxx_q) maxx_q <= hcont;
      if (vcont < miny_q) miny_q <= vcont;
      if (vcont > maxy_q) maxy_q <= vcont;
      any_q <= 1'b1;
    end
  end

  assign box     = '{hstart: minx_q, hend: maxx_q, vstart: miny_q, vend: maxy_q};
  assign any_lit = any_q;
endmodule

// File: rtl/detect_active_area.sv
// Measures the per-frame bounding box of lit pixels and publishes it once it has
// been identical for STABLE_FRAMES closes. Optional in_window: DETECT_AREA_INWINDOW_EN.
module detect_active_area
  import video_pkg::*;
#(
  parameter int CW            = 8,
  parameter int THRESHOLD     = 16,
  parameter int STABLE_FRAMES = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic [10:0]   hcont,
  input  logic [10:0]   vcont,
  input  logic          locked,
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  output logic [10:0]   hstart,
  output logic [10:0]   hend,
  output logic [10:0]   vstart,
  output logic [10:0]   vend,
  output logic          valid,
  output logic          frame_tick
`ifdef DETECT_AREA_INWINDOW_EN
  ,
  output logic          in_window
`endif
);
  localparam logic [CW-1:0] THR        = CW'(THRESHOLD);
  localparam logic [3:0]    STABLE_MAX = 4'(STABLE_FRAMES);

  state_t     state_q;
  box_t       box_q, cand_q, acc_box;
  logic       cand_vld_q, valid_q, tick_q, acc_any;
  logic [3:0] stable_q, stable_inc;
  logic       pix_lit, boundary, acc_load, acc_en, match;

  assign pix_lit  = (r > THR) || (g > THR) || (b > THR);
  assign boundary = clken && locked && (hcont == '0) && (vcont == '0);
  assign acc_load = boundary && (state_q != IDLE);
  assign acc_en   = clken && locked && (state_q == MEASURE);
  assign match    = cand_vld_q && (acc_box == cand_q);
  assign stable_inc = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;

  bbox_accum u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (acc_en),
    .load    (acc_load),
    .pix_lit (pix_lit),
    .hcont   (hcont),
    .vcont   (vcont),
    .box     (acc_box),
    .any_lit (acc_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      box_q      <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      stable_q   <= '0;
      valid_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      // Loss of lock aborts measurement at once; the published box is kept.
      if (!locked) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        stable_q   <= '0;
        cand_vld_q <= 1'b0;
      end else if (clken) begin
        case (state_q)
          IDLE:  state_q <= ALIGN;
          ALIGN: if (boundary) state_q <= MEASURE;
          MEASURE: if (boundary) begin
            tick_q <= 1'b1;
            if (!acc_any) begin
              cand_vld_q <= 1'b0;
              stable_q   <= '0;
              valid_q    <= 1'b0;
            end else if (match) begin
              stable_q <= stable_inc;
              if (stable_inc == STABLE_MAX) begin
                box_q   <= cand_q;
                valid_q <= 1'b1;
              end
            end else begin
              cand_q     <= acc_box;
              cand_vld_q <= 1'b1;
              stable_q   <= 4'd1;
              if (STABLE_MAX == 4'd1) begin
                box_q   <= acc_box;
                valid_q <= 1'b1;
              end else begin
                valid_q <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef DETECT_AREA_INWINDOW_EN
  logic in_window_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   in_window_q <= 1'b0;
    else if (clken) in_window_q <= valid_q &&
                                   (hcont >= box_q.hstart) && (hcont <= box_q.hend) &&
                                   (vcont >= box_q.vstart) && (vcont <= box_q.vend);
  end
  assign in_window = in_window_q;
`endif

  assign hstart     = box_q.hstart;
  assign hend       = box_q.hend;
  assign vstart     = box_q.vstart;
  assign vend       = box_q.vend;
  assign valid      = valid_q;
  assign frame_tick = tick_q;
endmodule
